// File: rtl/wb_skid_stage_pkg.sv
// Shared widths and reset polarity for the MEM->WB skid stage.
package wb_skid_stage_pkg;

  localparam int unsigned RegLen     = 32;
  localparam int unsigned RegAddrLen = 5;
  localparam logic        RstActive  = 1'b0;

endpackage

// File: rtl/wb_lane_slot.sv
// One held write-back entry: valid bit, LANES fields, capture sanitising and forward match.
module wb_lane_slot
  import wb_skid_stage_pkg::*;
#(
  parameter int unsigned DATA_W = RegLen,
  parameter int unsigned ADDR_W = RegAddrLen,
  parameter int unsigned LANES  = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic                    load,
  input  logic                    load_valid,
  input  logic [LANES*DATA_W-1:0] in_data,
  input  logic [LANES*ADDR_W-1:0] in_addr,
  input  logic [LANES-1:0]        in_en,
  output logic                    valid,
  output logic [LANES*DATA_W-1:0] data,
  output logic [LANES*ADDR_W-1:0] addr,
  output logic [LANES-1:0]        en,
  input  logic [ADDR_W-1:0]       fwd_addr,
  output logic                    fwd_hit,
  output logic [DATA_W-1:0]       fwd_data
);

  logic                    valid_q;
  logic [LANES*DATA_W-1:0] data_q;
  logic [LANES*ADDR_W-1:0] addr_q;
  logic [LANES-1:0]        en_q;
  logic [LANES-1:0]        clean_en;

  // Drop x0 writes; on an address clash only the highest enabled lane keeps its enable.
  always_comb begin
    clean_en = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      clean_en[i] = in_en[i] && (in_addr[i*ADDR_W +: ADDR_W] != '0);
      for (int unsigned j = i + 1; j < LANES; j++) begin
        if (in_en[j] && (in_addr[j*ADDR_W +: ADDR_W] == in_addr[i*ADDR_W +: ADDR_W])) begin
          clean_en[i] = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst == RstActive || flush) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      addr_q  <= '0;
      en_q    <= '0;
    end else if (load) begin
      valid_q <= load_valid;
      data_q  <= in_data;
      addr_q  <= in_addr;
      en_q    <= clean_en;
    end
  end

  assign valid = valid_q;
  assign data  = data_q;
  assign addr  = addr_q;
  assign en    = en_q;

  // Ascending scan so the highest matching lane wins.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      if (valid_q && en_q[i] && (fwd_addr != '0) &&
          (addr_q[i*ADDR_W +: ADDR_W] == fwd_addr)) begin
        fwd_hit  = 1'b1;
        fwd_data = data_q[i*DATA_W +: DATA_W];
      end
    end
  end

endmodule

// File: rtl/wb_skid_stage.sv
// MEM->WB pipeline stage with valid/ready handshake, optional skid entry, flush and forwarding.
module wb_skid_stage
  import wb_skid_stage_pkg::*;
#(
  parameter int unsigned DATA_W    = RegLen,
  parameter int unsigned ADDR_W    = RegAddrLen,
  parameter int unsigned LANES     = 1,
  parameter int unsigned SKID      = 1,
  parameter int unsigned STALL_W   = 6,
  parameter int unsigned STALL_BIT = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic [STALL_W-1:0]      stall,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [LANES*DATA_W-1:0] in_rd_data,
  input  logic [LANES*ADDR_W-1:0] in_rd_addr,
  input  logic [LANES-1:0]        in_rd_enable,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [LANES*DATA_W-1:0] out_rd_data,
  output logic [LANES*ADDR_W-1:0] out_rd_addr,
  output logic [LANES-1:0]        out_rd_enable,
  input  logic [ADDR_W-1:0]       fwd_addr,
  output logic                    fwd_hit,
  output logic [DATA_W-1:0]       fwd_data
);

  logic                    dn_ready, fire_in, fire_out, main_load, main_load_valid;
  logic                    main_v, main_hit, skid_v, skid_hit;
  logic [LANES*DATA_W-1:0] main_data, main_src_data, skid_data;
  logic [LANES*ADDR_W-1:0] main_addr, main_src_addr, skid_addr;
  logic [LANES-1:0]        main_en, main_src_en, skid_en;
  logic [DATA_W-1:0]       main_fwd, skid_fwd;
  logic                    unused_stall;

  assign unused_stall = ^stall;
  assign dn_ready     = out_ready & ~stall[STALL_BIT];
  assign fire_out     = main_v & dn_ready;
  assign fire_in      = in_valid & in_ready;
  assign main_load    = ~main_v | fire_out;

  if (SKID != 0) begin : gen_skid
    logic skid_load, skid_load_valid;

    // Registered ready: accept whenever the skid entry is free.
    assign in_ready        = ~skid_v;
    assign main_load_valid = skid_v | fire_in;
    assign main_src_data   = skid_v ? skid_data : in_rd_data;
    assign main_src_addr   = skid_v ? skid_addr : in_rd_addr;
    assign main_src_en     = skid_v ? skid_en : in_rd_enable;
    assign skid_load       = main_load | fire_in;
    assign skid_load_valid = ~main_load & fire_in;

    wb_lane_slot #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W),
      .LANES  (LANES)
    ) u_skid (
      .clk        (clk),
      .rst        (rst),
      .flush      (flush),
      .load       (skid_load),
      .load_valid (skid_load_valid),
      .in_data    (in_rd_data),
      .in_addr    (in_rd_addr),
      .in_en      (in_rd_enable),
      .valid      (skid_v),
      .data       (skid_data),
      .addr       (skid_addr),
      .en         (skid_en),
      .fwd_addr   (fwd_addr),
      .fwd_hit    (skid_hit),
      .fwd_data   (skid_fwd)
    );
  end else begin : gen_single
    assign in_ready        = ~main_v | dn_ready;
    assign main_load_valid = fire_in;
    assign main_src_data   = in_rd_data;
    assign main_src_addr   = in_rd_addr;
    assign main_src_en     = in_rd_enable;
    assign skid_v          = 1'b0;
    assign skid_data       = '0;
    assign skid_addr       = '0;
    assign skid_en         = '0;
    assign skid_hit        = 1'b0;
    assign skid_fwd        = '0;
  end

  wb_lane_slot #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .LANES  (LANES)
  ) u_main (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .load       (main_load),
    .load_valid (main_load_valid),
    .in_data    (main_src_data),
    .in_addr    (main_src_addr),
    .in_en      (main_src_en),
    .valid      (main_v),
    .data       (main_data),
    .addr       (main_addr),
    .en         (main_en),
    .fwd_addr   (fwd_addr),
    .fwd_hit    (main_hit),
    .fwd_data   (main_fwd)
  );

  assign out_valid     = main_v;
  assign out_rd_data   = main_v ? main_data : '0;
  assign out_rd_addr   = main_v ? main_addr : '0;
  assign out_rd_enable = main_v ? main_en : '0;

  // Skid holds the younger entry, so its match takes precedence.
  assign fwd_hit  = skid_hit | main_hit;
  assign fwd_data = skid_hit ? skid_fwd : main_fwd;

endmodule

// File: tb/tb_wb_skid_stage.sv
// Randomised and directed bench for wb_skid_stage (LANES=2, SKID=1) against a queue model.
module tb_wb_skid_stage;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 5;
  localparam int unsigned LN = 2;
  localparam int unsigned SW = 6;
  localparam int unsigned SB = 4;

  typedef struct packed {
    logic [LN-1:0][DW-1:0] data;
    logic [LN-1:0][AW-1:0] addr;
    logic [LN-1:0]         en;
  } entry_t;

  logic             clk = 1'b0;
  logic             rst, flush, in_valid, in_ready, out_valid, out_ready, fwd_hit;
  logic [SW-1:0]    stall;
  logic [LN*DW-1:0] in_rd_data, out_rd_data;
  logic [LN*AW-1:0] in_rd_addr, out_rd_addr;
  logic [LN-1:0]    in_rd_enable, out_rd_enable;
  logic [AW-1:0]    fwd_addr;
  logic [DW-1:0]    fwd_data;

  int     total = 0;
  int     bad = 0;
  bit     live = 1'b0;
  entry_t q[$];

  wb_skid_stage #(
    .DATA_W    (DW),
    .ADDR_W    (AW),
    .LANES     (LN),
    .SKID      (1),
    .STALL_W   (SW),
    .STALL_BIT (SB)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .flush         (flush),
    .stall         (stall),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_rd_data    (in_rd_data),
    .in_rd_addr    (in_rd_addr),
    .in_rd_enable  (in_rd_enable),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_rd_data   (out_rd_data),
    .out_rd_addr   (out_rd_addr),
    .out_rd_enable (out_rd_enable),
    .fwd_addr      (fwd_addr),
    .fwd_hit       (fwd_hit),
    .fwd_data      (fwd_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // A lane writes only if enabled, not x0, and no higher enabled lane targets the same register.
  function automatic entry_t sanitise(input entry_t e);
    entry_t r;
    r = e;
    for (int i = 0; i < LN; i++) begin
      r.en[i] = e.en[i] && (e.addr[i] != '0);
      for (int j = i + 1; j < LN; j++)
        if (e.en[j] && e.addr[j] == e.addr[i]) r.en[i] = 1'b0;
    end
    return r;
  endfunction

  function automatic entry_t cur_in();
    entry_t e;
    e.data = in_rd_data;
    e.addr = in_rd_addr;
    e.en   = in_rd_enable;
    return e;
  endfunction

  function automatic entry_t front();
    entry_t e;
    e = '0;
    if (q.size() > 0) e = q[0];
    return e;
  endfunction

  // Youngest entry first, higher lane first; returns {hit, data}.
  function automatic logic [DW:0] model_fwd();
    if (fwd_addr == '0) return '0;
    for (int k = q.size() - 1; k >= 0; k--)
      for (int l = LN - 1; l >= 0; l--)
        if (q[k].en[l] && q[k].addr[l] == fwd_addr) return {1'b1, q[k].data[l]};
    return '0;
  endfunction

  // Model: the stage is a FIFO of at most two accepted entries.
  always @(posedge clk) begin
    if (!rst) begin
      q.delete();
      live <= 1'b1;
    end else if (flush) begin
      q.delete();
    end else begin
      if (in_valid && q.size() < 2) begin
        if (q.size() > 0 && out_ready && !stall[SB]) void'(q.pop_front());
        q.push_back(sanitise(cur_in()));
      end else if (q.size() > 0 && out_ready && !stall[SB]) begin
        void'(q.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (live) begin
      chk("out_valid", 64'(out_valid), 64'(q.size() > 0));
      chk("in_ready", 64'(in_ready), 64'(q.size() < 2));
      chk("out_rd_data", 64'(out_rd_data), 64'(front().data));
      chk("out_rd_addr", 64'(out_rd_addr), 64'(front().addr));
      chk("out_rd_enable", 64'(out_rd_enable), 64'(front().en));
      chk("fwd", 64'({fwd_hit, fwd_data}), 64'(model_fwd()));
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic set_in(input logic v, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                        input logic e0, input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                        input logic e1);
    in_valid     = v;
    in_rd_addr   = {a1, a0};
    in_rd_data   = {d1, d0};
    in_rd_enable = {e1, e0};
  endtask

  initial begin
    rst = 1'b0; flush = 1'b0; stall = '0; out_ready = 1'b1; fwd_addr = 5'd3;
    set_in(1'b1, 5'd3, 32'hDD, 1'b1, 5'd0, 32'h0, 1'b0);
    repeat (3) tick();
    chk("reset_valid", 64'(out_valid), 64'd0);
    chk("reset_addr", 64'(out_rd_addr), 64'd0);
    chk("reset_data", 64'(out_rd_data), 64'd0);
    rst = 1'b1;
    in_valid = 1'b0;
    tick();
    chk("reset_in_ready", 64'(in_ready), 64'd1);
    chk("reset_fwd_hit", 64'(fwd_hit), 64'd0);

    // Stream of four entries, one per cycle, 1-cycle latency.
    for (int k = 1; k <= 4; k++) begin
      set_in(1'b1, 5'(k), 32'hA0 + 32'(k), 1'b1, 5'd0, 32'h0, 1'b0);
      tick();
      chk("stream_valid", 64'(out_valid), 64'd1);
      chk("stream_addr", 64'(out_rd_addr[AW-1:0]), 64'(k));
      chk("stream_data", 64'(out_rd_data[DW-1:0]), 64'(32'hA0 + 32'(k)));
      chk("stream_en", 64'(out_rd_enable), 64'd1);
    end
    in_valid = 1'b0;
    tick();
    chk("stream_drained", 64'(out_valid), 64'd0);

    // Backpressure: stall for three edges while entry 2 is at the output.
    set_in(1'b1, 5'd1, 32'hA1, 1'b1, 5'd0, 32'h0, 1'b0);
    tick();
    set_in(1'b1, 5'd2, 32'hA2, 1'b1, 5'd0, 32'h0, 1'b0);
    tick();
    stall = 6'b010000;
    set_in(1'b1, 5'd3, 32'hA3, 1'b1, 5'd0, 32'h0, 1'b0);
    tick();
    chk("bp_extra_accept_ready", 64'(in_ready), 64'd0);
    set_in(1'b1, 5'd4, 32'hA4, 1'b1, 5'd0, 32'h0, 1'b0);
    repeat (2) begin
      tick();
      chk("bp_hold_addr", 64'(out_rd_addr[AW-1:0]), 64'd2);
      chk("bp_hold_data", 64'(out_rd_data[DW-1:0]), 64'hA2);
      chk("bp_in_ready", 64'(in_ready), 64'd0);
    end
    stall = '0;
    tick();
    chk("bp_release_addr", 64'(out_rd_addr[AW-1:0]), 64'd3);
    tick();
    chk("bp_next_addr", 64'(out_rd_addr[AW-1:0]), 64'd4);
    in_valid = 1'b0;
    tick();
    chk("bp_no_dup", 64'(out_valid), 64'd0);

    // Sanitise: same-address conflict and an x0 write.
    set_in(1'b1, 5'd5, 32'h11, 1'b1, 5'd5, 32'h22, 1'b1);
    tick();
    chk("san_conflict_en", 64'(out_rd_enable), 64'd2);
    chk("san_conflict_data", 64'(out_rd_data[2*DW-1:DW]), 64'h22);
    set_in(1'b1, 5'd0, 32'h33, 1'b1, 5'd0, 32'h0, 1'b0);
    tick();
    chk("san_x0_valid", 64'(out_valid), 64'd1);
    chk("san_x0_en", 64'(out_rd_enable), 64'd0);
    in_valid = 1'b0;
    tick();

    // Flush with both entries held and a new entry offered.
    out_ready = 1'b0;
    set_in(1'b1, 5'd1, 32'hB1, 1'b1, 5'd0, 32'h0, 1'b0);
    tick();
    set_in(1'b1, 5'd2, 32'hB2, 1'b1, 5'd0, 32'h0, 1'b0);
    tick();
    chk("flush_pre_full", 64'(in_ready), 64'd0);
    set_in(1'b1, 5'd3, 32'hB3, 1'b1, 5'd0, 32'h0, 1'b0);
    flush = 1'b1;
    fwd_addr = 5'd1;
    tick();
    chk("flush_valid", 64'(out_valid), 64'd0);
    chk("flush_in_ready", 64'(in_ready), 64'd1);
    chk("flush_fwd_hit", 64'(fwd_hit), 64'd0);
    flush = 1'b0;
    in_valid = 1'b0;
    tick();
    chk("flush_discard", 64'(out_valid), 64'd0);

    // Forward: skid (younger) beats main on the same register.
    set_in(1'b1, 5'd7, 32'h70, 1'b1, 5'd0, 32'h0, 1'b0);
    tick();
    set_in(1'b1, 5'd7, 32'h77, 1'b1, 5'd0, 32'h0, 1'b0);
    tick();
    in_valid = 1'b0;
    fwd_addr = 5'd7;
    #1;
    chk("fwd_hit_7", 64'(fwd_hit), 64'd1);
    chk("fwd_data_7", 64'(fwd_data), 64'h77);
    fwd_addr = 5'd0;
    #1;
    chk("fwd_x0_hit", 64'(fwd_hit), 64'd0);
    chk("fwd_x0_data", 64'(fwd_data), 64'd0);
    flush = 1'b1;
    tick();
    flush = 1'b0;

    // Random traffic; small address range provokes lane conflicts and forwarding hits.
    for (int n = 0; n < 3000; n++) begin
      rst          = ($urandom_range(0, 299) != 0);
      flush        = ($urandom_range(0, 59) == 0);
      in_valid     = ($urandom_range(0, 3) != 0);
      out_ready    = ($urandom_range(0, 3) != 0);
      stall        = SW'($urandom);
      in_rd_addr   = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      in_rd_data   = {$urandom, $urandom};
      in_rd_enable = 2'($urandom_range(0, 3));
      fwd_addr     = 5'($urandom_range(0, 7));
      tick();
    end

    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1; stall = '0;
    repeat (3) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
